commit_retire_unit: RTL
=======================

COMMIT_RETIRE_UNIT -- requirements
Module: commit_retire_unit

Interface
REQ-001 Parameter NR_COMMIT_PORTS, default 2, range 1..4: number of scoreboard entries examined and retireable per cycle.
REQ-002 Parameter INSTRET_W, default 64: width of the retired-instruction counter.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 halt_i  in  1  suppress all retirement and exceptions.
REQ-006 flush_i  in  1  pipeline flush; aborts any pending drain or AMO wait.
REQ-007 single_step_i  in  1  limit retirement to port 0.
REQ-008 commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  oldest-first candidate instructions.
REQ-009 commit_ack_o  out  NR_COMMIT_PORTS  entry i retired this cycle.
REQ-010 waddr_o / wdata_o / we_gpr_o / we_fpr_o  out  per port 5 / XLEN / 1 / 1  register file write port i.
REQ-011 commit_lsu_o, commit_lsu_ready_i  out/in  1/1  store-commit handshake, port 0 only.
REQ-012 no_st_pending_i  in  1  store buffer empty.
REQ-013 amo_valid_commit_o, amo_resp_i  out/in  1/amo_resp_t  AMO request and response.
REQ-014 fence_o, fence_i_o, sfence_vma_o, flush_commit_o  out  1 each  one-cycle flush pulses.
REQ-015 exception_o  out  exception_t  exception taken on port 0.
REQ-016 instret_o  out  INSTRET_W  running count of retired instructions.

Function
REQ-017 FSM states SHALL be RUN, DRAIN, AMO_WAIT; DRAIN and AMO_WAIT latch the port-0 op kind.
REQ-018 In RUN, port 0 SHALL retire when valid, !ex.valid, !halt_i, and op is not FENCE/FENCE_I/SFENCE_VMA/AMO; a store additionally requires commit_lsu_ready_i, asserting commit_lsu_o in the same cycle.
REQ-019 Port k>0 SHALL retire only if ports 0..k-1 retire this cycle, entry k valid, !ex.valid, fu in {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC}, port 0 not CSR, and single_step_i low.
REQ-020 we_fpr_o[i] SHALL follow is_rd_fpr(op), else we_gpr_o[i]; both gated by commit_ack_o[i].
REQ-021 Port-0 FENCE, FENCE_I or SFENCE_VMA in RUN SHALL give no ack that cycle and enter DRAIN next cycle.
REQ-022 In DRAIN, on the first cycle with no_st_pending_i=1 and !halt_i, commit_ack_o[0] and the matching pulse (fence_o/fence_i_o/sfence_vma_o) SHALL assert for exactly that cycle; FSM returns to RUN next cycle.
REQ-023 Port-0 AMO in RUN SHALL enter AMO_WAIT next cycle; amo_valid_commit_o SHALL be high every AMO_WAIT cycle.
REQ-024 In AMO_WAIT, amo_resp_i.ack SHALL assert commit_ack_o[0], we_gpr_o[0], flush_commit_o, with wdata_o[0]=amo_resp_i.result, and return to RUN.
REQ-025 Port-0 ex.valid in RUN with !halt_i SHALL drive exception_o=ex and no acks; otherwise exception_o.valid=0.
REQ-026 instret_o SHALL increment by popcount(commit_ack_o) each cycle, wrapping modulo 2^INSTRET_W.
REQ-027 flush_i SHALL force RUN next cycle and mask all acks and pulses in its cycle; flush_i takes priority over a same-cycle no_st_pending_i or amo ack.
REQ-028 halt_i SHALL hold DRAIN/AMO_WAIT unchanged and mask acks, pulses and exception_o.valid.

Reset
REQ-029 During reset: FSM=RUN, instret_o=0; all acks, write enables, pulses, amo_valid_commit_o and exception_o.valid SHALL be 0.
REQ-030 Reset asserted mid-DRAIN or mid-AMO_WAIT SHALL abort the operation with no pulse emitted.

Configuration
REQ-031 Macro COMMIT_RETIRE_INSTRET_EN defined: instret_o counter implemented per REQ-026.
REQ-032 Macro undefined: no counter flops; instret_o tied to 0.

Verification
REQ-033 Two valid ALU entries, NR_COMMIT_PORTS=2 -> commit_ack_o=2'b11, instret_o +2 next cycle.
REQ-034 Port-0 store with commit_lsu_ready_i=0 for 3 cycles then 1 -> no ack 3 cycles, then ack+commit_lsu_o in cycle 4.
REQ-035 FENCE with no_st_pending_i low 2 DRAIN cycles -> fence_o single pulse on 3rd DRAIN cycle (4th cycle overall), ack same cycle.
REQ-036 AMO, amo_resp_i.ack after 5 cycles -> amo_valid_commit_o high 5 cycles, then ack, flush_commit_o, wdata_o[0]=result.
REQ-037 flush_i in same cycle as amo_resp_i.ack in AMO_WAIT -> no ack, no flush_commit_o, RUN next cycle.
REQ-038 Port-1 ex.valid with port 0 ALU -> ack=2'b01, exception_o.valid=0; port-0 ex.valid with halt_i=1 -> exception_o.valid=0.

Source files
------------

// File: rtl/commit_retire_unit.sv
// commit_retire_unit
// Retires up to NR_COMMIT_PORTS oldest-first scoreboard entries per cycle.
// Fences drain the store buffer and AMOs wait for the memory response before
// port 0 retires them. Exceptions are taken on port 0 only.
//
// Optional feature: define COMMIT_RETIRE_INSTRET_EN to build the
// retired-instruction counter. Without it instret_o is tied to zero and no
// counter flops exist.
//
// Scoreboard entries arrive flattened into per-port vectors:
//   fu encoding : 0 NONE, 1 LOAD, 2 STORE, 3 ALU, 4 CTRL_FLOW, 5 MULT,
//                 6 CSR, 7 FPU, 8 FPU_VEC
//   op encoding : 0 generic integer op, 1 FENCE, 2 FENCE_I, 3 SFENCE_VMA,
//                 4 AMO, 5 FLD, 6 FADD, 7 FCVT_W (FPU op writing a GPR)
// Ports k>0 only ever retire alongside a plain port-0 retirement in RUN,
// so fences and AMOs always retire alone.

module commit_retire_unit #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned INSTRET_W       = 64,
    parameter int unsigned XLEN            = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 halt_i,
    input  logic                                 flush_i,
    input  logic                                 single_step_i,
    input  logic [NR_COMMIT_PORTS-1:0]           commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][3:0]      commit_fu_i,
    input  logic [NR_COMMIT_PORTS-1:0][3:0]      commit_op_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]      commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_result_i,
    input  logic [NR_COMMIT_PORTS-1:0]           commit_ex_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_ex_cause_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_ex_tval_i,
    output logic [NR_COMMIT_PORTS-1:0]           commit_ack_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]      waddr_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata_o,
    output logic [NR_COMMIT_PORTS-1:0]           we_gpr_o,
    output logic [NR_COMMIT_PORTS-1:0]           we_fpr_o,
    output logic                                 commit_lsu_o,
    input  logic                                 commit_lsu_ready_i,
    input  logic                                 no_st_pending_i,
    output logic                                 amo_valid_commit_o,
    input  logic                                 amo_resp_ack_i,
    input  logic [XLEN-1:0]                      amo_resp_result_i,
    output logic                                 fence_o,
    output logic                                 fence_i_o,
    output logic                                 sfence_vma_o,
    output logic                                 flush_commit_o,
    output logic                                 exception_valid_o,
    output logic [XLEN-1:0]                      exception_cause_o,
    output logic [XLEN-1:0]                      exception_tval_o,
    output logic [INSTRET_W-1:0]                 instret_o
);

    localparam logic [3:0] FU_LOAD      = 4'd1;
    localparam logic [3:0] FU_STORE     = 4'd2;
    localparam logic [3:0] FU_ALU       = 4'd3;
    localparam logic [3:0] FU_CTRL_FLOW = 4'd4;
    localparam logic [3:0] FU_MULT      = 4'd5;
    localparam logic [3:0] FU_CSR       = 4'd6;
    localparam logic [3:0] FU_FPU       = 4'd7;
    localparam logic [3:0] FU_FPU_VEC   = 4'd8;

    localparam logic [3:0] OP_FENCE      = 4'd1;
    localparam logic [3:0] OP_FENCE_I    = 4'd2;
    localparam logic [3:0] OP_SFENCE_VMA = 4'd3;
    localparam logic [3:0] OP_AMO        = 4'd4;
    localparam logic [3:0] OP_FLD        = 4'd5;
    localparam logic [3:0] OP_FADD       = 4'd6;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        AMO_WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] kind_q, kind_d;
    logic       amo_writeback;
    logic       retire_chain;
    logic       unused_ex_bits;

    function automatic logic is_rd_fpr(input logic [3:0] op);
        return (op == OP_FLD) || (op == OP_FADD);
    endfunction

    function automatic logic is_fence_op(input logic [3:0] op);
        return (op == OP_FENCE) || (op == OP_FENCE_I) || (op == OP_SFENCE_VMA);
    endfunction

    function automatic logic fu_parallel_ok(input logic [3:0] fu);
        return (fu == FU_LOAD) || (fu == FU_ALU) || (fu == FU_CTRL_FLOW) ||
               (fu == FU_MULT) || (fu == FU_FPU) || (fu == FU_FPU_VEC);
    endfunction

    // Only port 0 can raise an exception; younger ports' cause/tval are ignored.
    assign unused_ex_bits    = ^{commit_ex_cause_i, commit_ex_tval_i};
    assign exception_cause_o = commit_ex_cause_i[0];
    assign exception_tval_o  = commit_ex_tval_i[0];

    // State register plus the op kind latched when a fence or AMO is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            kind_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    // Retire decision, next state and one-cycle pulses; everything is held low while in reset.
    always_comb begin
        state_d            = state_q;
        kind_d             = kind_q;
        commit_ack_o       = '0;
        commit_lsu_o       = 1'b0;
        amo_valid_commit_o = 1'b0;
        amo_writeback      = 1'b0;
        fence_o            = 1'b0;
        fence_i_o          = 1'b0;
        sfence_vma_o       = 1'b0;
        flush_commit_o     = 1'b0;
        exception_valid_o  = 1'b0;
        retire_chain       = 1'b0;

        if (rst_ni) begin
            case (state_q)
                RUN: begin
                    if (commit_valid_i[0] && !halt_i) begin
                        if (commit_ex_valid_i[0]) begin
                            exception_valid_o = 1'b1;
                        end else if (is_fence_op(commit_op_i[0])) begin
                            if (!flush_i) begin
                                state_d = DRAIN;
                                kind_d  = commit_op_i[0];
                            end
                        end else if (commit_op_i[0] == OP_AMO) begin
                            if (!flush_i) begin
                                state_d = AMO_WAIT;
                                kind_d  = commit_op_i[0];
                            end
                        end else if (commit_fu_i[0] == FU_STORE) begin
                            if (commit_lsu_ready_i && !flush_i) begin
                                commit_ack_o[0] = 1'b1;
                                commit_lsu_o    = 1'b1;
                            end
                        end else if (!flush_i) begin
                            commit_ack_o[0] = 1'b1;
                        end
                    end

                    retire_chain = commit_ack_o[0] && !single_step_i &&
                                   (commit_fu_i[0] != FU_CSR);
                    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
                        retire_chain = retire_chain && commit_valid_i[k] &&
                                       !commit_ex_valid_i[k] &&
                                       fu_parallel_ok(commit_fu_i[k]);
                        commit_ack_o[k] = retire_chain;
                    end
                end

                DRAIN: begin
                    if (flush_i) begin
                        state_d = RUN;
                    end else if (!halt_i && no_st_pending_i) begin
                        commit_ack_o[0] = 1'b1;
                        fence_o         = (kind_q == OP_FENCE);
                        fence_i_o       = (kind_q == OP_FENCE_I);
                        sfence_vma_o    = (kind_q == OP_SFENCE_VMA);
                        state_d         = RUN;
                    end
                end

                AMO_WAIT: begin
                    amo_valid_commit_o = 1'b1;
                    if (flush_i) begin
                        state_d = RUN;
                    end else if (!halt_i && amo_resp_ack_i) begin
                        commit_ack_o[0] = 1'b1;
                        flush_commit_o  = 1'b1;
                        amo_writeback   = 1'b1;
                        state_d         = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Register file write ports; an AMO writes its memory result into a GPR.
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            waddr_o[i]  = commit_rd_i[i];
            wdata_o[i]  = commit_result_i[i];
            we_fpr_o[i] = commit_ack_o[i] && is_rd_fpr(commit_op_i[i]);
            we_gpr_o[i] = commit_ack_o[i] && !is_rd_fpr(commit_op_i[i]);
        end
        if (amo_writeback) begin
            wdata_o[0]  = amo_resp_result_i;
            we_gpr_o[0] = 1'b1;
            we_fpr_o[0] = 1'b0;
        end
    end

`ifdef COMMIT_RETIRE_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] retire_count;

    // Number of instructions retired this cycle.
    always_comb begin
        retire_count = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            retire_count = retire_count + INSTRET_W'(commit_ack_o[i]);
        end
    end

    // Running retired-instruction count, wrapping naturally at its width.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_q + retire_count;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule
